// File: rtl/cdm_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cdm_err_monitor
// Purpose  : Error-distance monitor for an approximate multiplier. Each
//            accepted sample (A, B, R) is checked by computing the exact
//            unsigned product A*B with a bit-serial shift-add multiplier and
//            comparing it with the approximate product R. The absolute
//            difference (error distance, ED) feeds running statistics.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            in_valid/in_ready   - sample handshake (in_a, in_b, in_r)
//            clear               - synchronous statistics clear (top priority)
//            busy                - a sample is being evaluated
//            upd                 - one-cycle pulse, statistics just updated
//            last_ed             - ED of the most recent sample
//            sample_count        - samples evaluated (saturating)
//            err_count           - samples with nonzero ED (saturating)
//            sum_ed              - accumulated ED (saturating)
//            max_ed              - largest ED seen
// Revision : 1.0 - initial release
// ============================================================================
module cdm_err_monitor #(
    parameter int W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic [2*W-1:0]    in_r,
    input  logic              clear,
    output logic              busy,
    output logic              upd,
    output logic [2*W-1:0]    last_ed,
    output logic [31:0]       sample_count,
    output logic [31:0]       err_count,
    output logic [2*W+15:0]   sum_ed,
    output logic [2*W-1:0]    max_ed
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2
    } state_t;

    state_t            r_state;
    logic [2*W-1:0]    r_mcand;     // operand A, shifted left once per MUL cycle
    logic [W-1:0]      r_mplier;    // operand B, shifted right once per MUL cycle
    logic [2*W-1:0]    r_r;         // approximate product under test
    logic [2*W-1:0]    r_acc;       // exact-product accumulator
    logic [CW-1:0]     r_cnt;       // multiplier bits still to process
    logic              r_busy;
    logic              r_upd;
    logic [2*W-1:0]    r_last_ed;
    logic [31:0]       r_sc;
    logic [31:0]       r_ec;
    logic [2*W+15:0]   r_sum;
    logic [2*W-1:0]    r_max;

    logic [2*W-1:0]    w_ed;
    logic [2*W+16:0]   w_sum_ext;   // one spare bit to detect overflow
    logic [2*W-1:0]    w_acc_next;

    // Absolute difference, valid whichever way the approximation errs.
    assign w_ed       = (r_acc >= r_r) ? (r_acc - r_r) : (r_r - r_acc);
    assign w_sum_ext  = {1'b0, r_sum} + {17'd0, w_ed};
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Accepting is suppressed while clear is asserted so a sample is never
    // taken in the same cycle the statistics are being wiped.
    assign in_ready     = (r_state == IDLE) && !clear;
    assign busy         = r_busy;
    assign upd          = r_upd;
    assign last_ed      = r_last_ed;
    assign sample_count = r_sc;
    assign err_count    = r_ec;
    assign sum_ed       = r_sum;
    assign max_ed       = r_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_r       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_upd     <= 1'b0;
            r_last_ed <= '0;
            r_sc      <= '0;
            r_ec      <= '0;
            r_sum     <= '0;
            r_max     <= '0;
        end else if (clear) begin
            // Clear wins over everything, including a coinciding CMP commit.
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_upd     <= 1'b0;
            r_last_ed <= '0;
            r_sc      <= '0;
            r_ec      <= '0;
            r_sum     <= '0;
            r_max     <= '0;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{W{1'b0}}, in_a};
                        r_mplier <= in_b;
                        r_r      <= in_r;
                        r_acc    <= '0;
                        r_cnt    <= CW'(W);
                        r_busy   <= 1'b1;
                        r_state  <= MUL;
                    end
                end
                MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= CMP;
                    end
                end
                CMP: begin
                    r_last_ed <= w_ed;
                    if (r_sc != 32'hFFFF_FFFF) begin
                        r_sc <= r_sc + 32'd1;
                    end
                    if ((w_ed != '0) && (r_ec != 32'hFFFF_FFFF)) begin
                        r_ec <= r_ec + 32'd1;
                    end
                    r_sum <= w_sum_ext[2*W+16] ? '1 : w_sum_ext[2*W+15:0];
                    if (w_ed > r_max) begin
                        r_max <= w_ed;
                    end
                    r_upd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdm_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdm_err_monitor
// Purpose  : Scoreboard bench for cdm_err_monitor. A stimulus process issues
//            samples and pushes the statistics a reference model predicts;
//            a monitor pops and compares on every upd pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdm_err_monitor;

    localparam int W = 16;

    typedef struct packed {
        logic [2*W-1:0]  ed;
        logic [31:0]     sc;
        logic [31:0]     ec;
        logic [2*W+15:0] sum;
        logic [2*W-1:0]  mx;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_a = '0;
    logic [W-1:0]    in_b = '0;
    logic [2*W-1:0]  in_r = '0;
    logic            clear = 1'b0;
    logic            busy;
    logic            upd;
    logic [2*W-1:0]  last_ed;
    logic [31:0]     sample_count;
    logic [31:0]     err_count;
    logic [2*W+15:0] sum_ed;
    logic [2*W-1:0]  max_ed;

    int n_vec = 0;
    int n_err = 0;
    exp_t sb_q[$];

    // Reference statistics
    logic [2*W-1:0]  m_ed;
    logic [31:0]     m_sc;
    logic [31:0]     m_ec;
    logic [2*W+15:0] m_sum;
    logic [2*W-1:0]  m_mx;

    cdm_err_monitor #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_r         (in_r),
        .clear        (clear),
        .busy         (busy),
        .upd          (upd),
        .last_ed      (last_ed),
        .sample_count (sample_count),
        .err_count    (err_count),
        .sum_ed       (sum_ed),
        .max_ed       (max_ed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_ed = '0; m_sc = '0; m_ec = '0; m_sum = '0; m_mx = '0;
    endtask

    // Statistics after one evaluated sample, from the arithmetic definition.
    task automatic model_sample(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2*W-1:0] r);
        longint unsigned ex, rr, d, s;
        exp_t e;
        ex = longint'(a) * longint'(b);
        rr = longint'(r);
        d  = (ex > rr) ? ex - rr : rr - ex;
        m_ed = d[2*W-1:0];
        if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        if (d != 0 && m_ec != 32'hFFFF_FFFF) m_ec = m_ec + 1;
        s = longint'(m_sum) + d;
        m_sum = (s > 64'h0000_FFFF_FFFF_FFFF) ? '1 : s[2*W+15:0];
        if (m_ed > m_mx) m_mx = m_ed;
        e = '{ed: m_ed, sc: m_sc, ec: m_ec, sum: m_sum, mx: m_mx};
        sb_q.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_last_ed"}, 64'(last_ed), 64'd0);
        chk({tag, "_sample_count"}, 64'(sample_count), 64'd0);
        chk({tag, "_err_count"}, 64'(err_count), 64'd0);
        chk({tag, "_sum_ed"}, 64'(sum_ed), 64'd0);
        chk({tag, "_max_ed"}, 64'(max_ed), 64'd0);
    endtask

    // Present a sample and complete the handshake; returns just after the
    // accepting edge. push=0 means the sample is expected to be aborted.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] r, input bit hold, input bit push);
        int n;
        in_a = a; in_b = b; in_r = r; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk("ready_wait", 64'(n < 40), 64'd1);
        @(posedge clk);
        if (push) model_sample(a, b, r);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Wait for upd; k counts negedges since the accepting edge.
    task automatic wait_upd(input bit hold, output int k, output int lowcnt);
        lowcnt = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!in_ready) lowcnt++;
            if (upd) break;
            if (hold) begin
                in_a = W'($urandom); in_b = W'($urandom); in_r = $urandom;
            end
        end
        in_valid = 1'b0;
        chk("upd_timeout", 64'(k <= 40), 64'd1);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] r);
        int k, lowcnt;
        start(a, b, r, 1'b0, 1'b1);
        wait_upd(1'b0, k, lowcnt);
        chk("latency_edges", 64'(k - 1), 64'(W + 1));
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("ready_during_clear", 64'(in_ready), 64'd0);
        @(negedge clk);
        clear = 1'b0;
        model_zero();
        chk_zero("after_clear");
    endtask

    // Monitor: every upd pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst && upd) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_upd", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("last_ed", 64'(last_ed), 64'(e.ed));
                chk("sample_count", 64'(sample_count), 64'(e.sc));
                chk("err_count", 64'(err_count), 64'(e.ec));
                chk("sum_ed", 64'(sum_ed), 64'(e.sum));
                chk("max_ed", 64'(max_ed), 64'(e.mx));
                chk("busy_at_upd", 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        int k, lowcnt;
        logic [2*W-1:0] ex;
        logic [W-1:0] ra, rb;
        logic [2*W-1:0] rr;

        model_zero();
        rst = 1'b1;
        in_valid = 1'b1; in_a = 16'd3; in_b = 16'd5; in_r = 32'd15;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_upd", 64'(upd), 64'd0);
        chk_zero("rst");

        // First accepted on the first rising edge after reset release.
        rst = 1'b0;
        send(16'd3, 16'd5, 32'd15);
        send(16'hFFFF, 16'hFFFF, 32'd0);

        do_clear();
        send(16'd2, 16'd2, 32'd10);
        send(16'd4, 16'd4, 32'd12);

        // in_valid held with changing operands during evaluation.
        start(16'd5, 16'd6, 32'd31, 1'b1, 1'b1);
        wait_upd(1'b1, k, lowcnt);
        chk("hold_ready_low_cycles", 64'(lowcnt), 64'd17);
        chk("hold_latency_edges", 64'(k - 1), 64'(W + 1));
        repeat (3) @(negedge clk);
        chk("hold_no_extra_sample", 64'(sample_count), 64'(m_sc));

        // Reset in the middle of MUL discards the sample.
        start(16'd11, 16'd13, 32'd0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("mid_mul_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk_zero("midrst");
        model_zero();
        @(negedge clk);
        rst = 1'b0;
        send(16'd7, 16'd9, 32'd63);

        // Clear coinciding with the CMP cycle.
        start(16'd1, 16'd1, 32'd0, 1'b0, 1'b0);
        repeat (W + 1) @(negedge clk);
        chk("cmp_busy", 64'(busy), 64'd1);
        clear = 1'b1;
        @(negedge clk);
        chk("clear_cmp_upd", 64'(upd), 64'd0);
        chk("clear_cmp_busy", 64'(busy), 64'd0);
        clear = 1'b0;
        #1;
        chk("clear_cmp_idle", 64'(in_ready), 64'd1);
        chk_zero("clear_cmp");
        model_zero();

        // Randomized samples, with error in both directions and exact hits.
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 5 == 0) ra = '0;
            if (i % 7 == 3) rb = '0;
            ex = 32'(ra) * 32'(rb);
            case ($urandom_range(0, 3))
                0: rr = ex;
                1: rr = ex + 32'($urandom_range(1, 1000));
                2: rr = ex - 32'($urandom_range(1, 1000));
                default: rr = $urandom;
            endcase
            send(ra, rb, rr);
            if (i == 11) do_clear();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
